// File: rtl/eru_stats_pkg.sv
// eru_stats_pkg: shared state encoding and default sizes for the error-statistics collector.
package eru_stats_pkg;
    localparam int DEF_W      = 8;
    localparam int DEF_N_LOG2 = 8;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;
endpackage

// File: rtl/eru_err_dist.sv
// eru_err_dist: exact sum of a and b and its absolute distance from the approximate sum.
module eru_err_dist #(
    parameter int W = 8
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W:0]   approx_i,
    output logic [W:0]   ed_o
);
    logic [W:0] exact;
    assign exact = {1'b0, a_i} + {1'b0, b_i};
    assign ed_o  = (exact >= approx_i) ? exact - approx_i : approx_i - exact;
endmodule

// File: rtl/eru_err_stats.sv
// eru_err_stats: windowed error count, maximum and total error distance with a
// valid/ready report at the end of each window of 2^N_LOG2 accepted samples.
module eru_err_stats
    import eru_stats_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int N_LOG2 = DEF_N_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [W-1:0]          a_i,
    input  logic [W-1:0]          b_i,
    input  logic [W:0]            approx_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [N_LOG2:0]       err_cnt_o,
    output logic [W:0]            max_ed_o,
    output logic [W+N_LOG2:0]     sum_ed_o,
    output logic                  busy_o
);
    localparam logic [N_LOG2:0] LAST = {1'b0, {N_LOG2{1'b1}}};
    state_t              state_q, state_d;
    logic [N_LOG2:0]     cnt_q, cnt_d, err_q, err_d;
    logic [W:0]          ed, ed_q, ed_d, max_q, max_d;
    logic [W+N_LOG2:0]   sum_q, sum_d;
    logic                s1_v_q, s1_v_d, accept;
    eru_err_dist #(.W(W)) u_dist (
        .a_i      (a_i),
        .b_i      (b_i),
        .approx_i (approx_i),
        .ed_o     (ed)
    );
    // counter MSB set means the window is full, so in_ready depends on registers only
    assign in_ready_o  = (state_q == RUN) && !cnt_q[N_LOG2];
    assign accept      = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == REPORT);
    assign busy_o      = (state_q != IDLE);
    assign err_cnt_o   = err_q;
    assign max_ed_o    = max_q;
    assign sum_ed_o    = sum_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ed_d    = ed_q;
        s1_v_d  = 1'b0;
        err_d   = s1_v_q ? err_q + (N_LOG2+1)'(ed_q != '0) : err_q;
        max_d   = (s1_v_q && ed_q > max_q) ? ed_q : max_q;
        sum_d   = s1_v_q ? sum_q + (W+1+N_LOG2)'(ed_q) : sum_q;
        unique case (state_q)
            IDLE: if (start_i) begin
                state_d = RUN;
                cnt_d   = '0;
                err_d   = '0;
                max_d   = '0;
                sum_d   = '0;
            end
            RUN: if (accept) begin
                cnt_d   = cnt_q + (N_LOG2+1)'(1);
                ed_d    = ed;
                s1_v_d  = 1'b1;
                state_d = (cnt_q == LAST) ? DRAIN : RUN;
            end
            DRAIN:  state_d = REPORT;
            REPORT: state_d = out_ready_i ? IDLE : REPORT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ed_q    <= '0;
            s1_v_q  <= 1'b0;
            err_q   <= '0;
            max_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ed_q    <= ed_d;
            s1_v_q  <= s1_v_d;
            err_q   <= err_d;
            max_q   <= max_d;
            sum_q   <= sum_d;
        end
    end
endmodule

// File: tb/tb_eru_err_stats.sv
// tb_eru_err_stats: directed checks of the error-statistics collector with a 4-sample window.
module tb_eru_err_stats;
    localparam int W = 8;
    localparam int N = 2;
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
    logic [W-1:0]   a_i = '0, b_i = '0;
    logic [W:0]     approx_i = '0;
    logic           in_ready_o, out_valid_o, busy_o;
    logic [N:0]     err_cnt_o;
    logic [W:0]     max_ed_o;
    logic [W+N:0]   sum_ed_o;
    int total = 0;
    int bad = 0;
    eru_err_stats #(.W(W), .N_LOG2(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .approx_i    (approx_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .err_cnt_o   (err_cnt_o),
        .max_ed_o    (max_ed_o),
        .sum_ed_o    (sum_ed_o),
        .busy_o      (busy_o)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] ap);
        in_valid_i = 1'b1;
        a_i = a;
        b_i = b;
        approx_i = ap;
        tick();
    endtask
    task automatic chk_stats(input string tag, input int e, input int m, input int s);
        chk({tag, "_err"}, 32'(err_cnt_o), 32'(e));
        chk({tag, "_max"}, 32'(max_ed_o), 32'(m));
        chk({tag, "_sum"}, 32'(sum_ed_o), 32'(s));
    endtask
    task automatic open_window();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask
    task automatic finish_window(input string tag, input int e, input int m, input int s);
        in_valid_i = 1'b0;
        chk({tag, "_drain_ov"}, 32'(out_valid_o), 0);
        chk({tag, "_drain_rdy"}, 32'(in_ready_o), 0);
        tick();
        chk({tag, "_ov"}, 32'(out_valid_o), 1);
        chk_stats(tag, e, m, s);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk({tag, "_idle_ov"}, 32'(out_valid_o), 0);
        chk({tag, "_idle_busy"}, 32'(busy_o), 0);
        chk_stats({tag, "_held"}, e, m, s);
    endtask
    initial begin
        #12 rst_n = 1'b1;
        tick();
        chk("rst_rdy", 32'(in_ready_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ov", 32'(out_valid_o), 0);
        chk_stats("rst", 0, 0, 0);
        // two accepts then asynchronous reset between edges
        open_window();
        chk("run_rdy", 32'(in_ready_o), 1);
        chk("run_busy", 32'(busy_o), 1);
        feed(8'd1, 8'd1, 9'd0);
        feed(8'd1, 8'd1, 9'd0);
        in_valid_i = 1'b0;
        chk_stats("pre_rst", 1, 2, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rdy", 32'(in_ready_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        chk("arst_ov", 32'(out_valid_o), 0);
        chk_stats("arst", 0, 0, 0);
        #1 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy_o), 0);
        chk("post_rst_rdy", 32'(in_ready_o), 0);
        // exact samples
        open_window();
        for (int i = 0; i < 4; i++) feed(8'd3, 8'd5, 9'd8);
        finish_window("exact", 0, 0, 0);
        // eds 4, 0, 510, 1
        open_window();
        feed(8'd3, 8'd5, 9'd12);
        feed(8'd10, 8'd20, 9'd30);
        feed(8'd255, 8'd255, 9'd0);
        feed(8'd1, 8'd1, 9'd1);
        finish_window("mix", 3, 510, 515);
        // approx above exact: eds 511, 0, 0, 1
        open_window();
        feed(8'd0, 8'd0, 9'h1FF);
        feed(8'd10, 8'd20, 9'd30);
        feed(8'd200, 8'd100, 9'd300);
        feed(8'd128, 8'd128, 9'd255);
        finish_window("above", 2, 511, 512);
        // start with in_valid high, gapped input, stalled report
        start_i = 1'b1;
        in_valid_i = 1'b1;
        a_i = 8'd1;
        b_i = 8'd0;
        approx_i = 9'd0;
        chk("idle_start_rdy", 32'(in_ready_o), 0);
        tick();
        start_i = 1'b0;
        chk("gap_run_rdy", 32'(in_ready_o), 1);
        chk_stats("gap_cleared", 0, 0, 0);
        feed(8'd1, 8'd0, 9'd0);
        in_valid_i = 1'b0;
        a_i = 8'd255;
        tick();
        feed(8'd2, 8'd2, 9'd0);
        in_valid_i = 1'b0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        feed(8'd0, 8'd0, 9'd3);
        chk("gap_rdy3", 32'(in_ready_o), 1);
        chk_stats("gap_mid", 2, 4, 5);
        in_valid_i = 1'b0;
        a_i = 8'd255;
        b_i = 8'd0;
        approx_i = 9'd0;
        tick();
        feed(8'd5, 8'd5, 9'd10);
        in_valid_i = 1'b0;
        start_i = 1'b1;
        chk("gap_drain_rdy", 32'(in_ready_o), 0);
        chk("gap_drain_ov", 32'(out_valid_o), 0);
        tick();
        chk("gap_ov", 32'(out_valid_o), 1);
        chk_stats("gap", 3, 4, 8);
        for (int i = 0; i < 5; i++) begin
            start_i = 1'b1;
            in_valid_i = 1'b1;
            tick();
            chk("stall_ov", 32'(out_valid_o), 1);
            chk("stall_rdy", 32'(in_ready_o), 0);
            chk_stats("stall", 3, 4, 8);
        end
        start_i = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("gap_idle_ov", 32'(out_valid_o), 0);
        chk("gap_idle_busy", 32'(busy_o), 0);
        chk_stats("gap_held", 3, 4, 8);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
